capture_accumulator: RTL and testbench
======================================

Name: capture_accumulator

Overview:
- Parametrised successor to the single-event fast-capture path.
- Per trigger, captures a fixed-length record of samples and sums it element-wise into an on-chip accumulator RAM over NUM_EVENTS triggers, then streams the accumulated record out over a valid/ready interface.
- Sits between the ADC sample bus and the transmit FIFO; single clock domain.

Parameters:
- DATA_W, 8, sample width (bits)
- ACC_W, 16, accumulator/output word width; must be >= DATA_W
- RECORD_LEN, 128, samples per record; must be >= 2
- ADDR_W, 7, RAM address width; 2^ADDR_W >= RECORD_LEN
- NUM_EVENTS, 4, triggers accumulated per output record; must be >= 1
- EVT_W, 8, width of event counter; 2^EVT_W > NUM_EVENTS

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- sample_in  in  DATA_W  sample bus, new sample every clk
- trig  in  1  capture strobe, single-cycle or level; rising-edge detected internally
- capture_en  in  1  arms trigger acceptance while high
- out_ready  in  1  downstream accepts word when high
- out_data  out  ACC_W  accumulated (or averaged) sample
- out_valid  out  1  out_data valid
- out_last  out  1  high with final word (index RECORD_LEN-1) of record
- busy  out  1  high in any state except WAIT_TRIG
- event_count  out  EVT_W  events accumulated in current record
- sat_flag  out  1  sticky; some accumulation saturated in current record

Behaviour:
- Reset (async assert, sync release): state IDLE; out_data=0, out_valid=0, out_last=0, busy=1, event_count=0, sat_flag=0; edge-detect register cleared. RAM contents undefined; no clear cycle required.
- IDLE -> WAIT_TRIG unconditionally next cycle.
- WAIT_TRIG: busy=0. Rising edge of trig (trig=1, previous trig=0) while capture_en=1 -> CAPTURE. sample_in on that same cycle is index 0.
- CAPTURE: one sample per cycle, indices 0..RECORD_LEN-1, no gaps.
  - event_count==0: RAM[i] <= zero-extended sample.
  - Otherwise: RAM[i] <= RAM[i] + sample, saturating at 2^ACC_W-1; any saturation sets sat_flag.
  - Read-modify-write may be pipelined, but same-address hazards must be forwarded so every sample is summed exactly once.
  - After index RECORD_LEN-1 -> NEXT.
- trig edges during CAPTURE, NEXT, READOUT: ignored, not queued.
- NEXT: event_count increments. If new count == NUM_EVENTS -> READOUT, else -> WAIT_TRIG.
- READOUT:
  - Words emitted in index order 0..RECORD_LEN-1.
  - First out_valid no later than 3 cycles after entering READOUT.
  - Transfer occurs on out_valid & out_ready. out_data/out_last held stable while out_valid & ~out_ready.
  - out_valid never drops before transfer. Sustains 1 word/cycle under constant out_ready=1.
  - out_last=1 only with index RECORD_LEN-1.
  - After last transfer: event_count=0, sat_flag=0, out_valid=0 -> WAIT_TRIG.
- capture_en low mid-record: no effect on a record in progress; only gates acceptance in WAIT_TRIG.
- rst mid-operation: immediate return to reset values; partial accumulation discarded. The next record starts from event 0, which overwrites stale RAM.
- Widths: all sums computed in ACC_W+1 bits before saturation; no wrap-around permitted.

Optional Feature:
- Macro CAPTURE_ACC_AVG_EN.
- Defined: out_data = saturated sum >> log2(NUM_EVENTS), zero-extended to ACC_W. NUM_EVENTS must be a power of two (elaboration-time error otherwise). sat_flag behaviour unchanged.
- Undefined: out_data = raw saturated sum. No shifter logic present.

Test Plan (DATA_W=8, ACC_W=16, RECORD_LEN=8, NUM_EVENTS=4 unless stated):
- 4 triggers, sample_in ramp 0..7 each record, out_ready=1 -> out_data 0,4,8,...,28 on 8 consecutive cycles; out_last only on 28; sat_flag=0; returns to WAIT_TRIG, busy=0.
- Same stimulus, out_ready pattern 1,0,0,1 repeating -> identical 8-word sequence, each word held stable while stalled, no drop or duplicate.
- ACC_W=9, samples constant 0xFF, 4 events -> every word 0x1FF (saturated from 0x3FC), sat_flag=1 until last transfer, then 0.
- Extra trig pulses mid-CAPTURE and during READOUT, plus capture_en=0 at a trig in WAIT_TRIG -> event_count advances only on accepted triggers; output sums equal exactly 4 records.
- rst asserted after 2 events, mid-third capture, asynchronously between edges -> all outputs zero immediately; next 4 events of constant 10 -> every word 40.
- CAPTURE_ACC_AVG_EN defined, samples constant 200 for 4 events -> every word 200; with 3 events of 200 and one of 0 -> 150.

Source files
------------

// File: rtl/capture_accumulator.sv
// capture_accumulator: sums NUM_EVENTS triggered sample records into a RAM, then streams the record out.
// Optional macro CAPTURE_ACC_AVG_EN: output is the sum divided by NUM_EVENTS (power of two).
module capture_accumulator #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned RECORD_LEN = 128,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned EVT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              trig,
  input  logic              capture_en,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic [EVT_W-1:0]  event_count,
  output logic              sat_flag
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(RECORD_LEN - 1);
  localparam logic [CNT_W-1:0]  REC_CNT    = CNT_W'(RECORD_LEN);
  localparam logic [EVT_W-1:0]  EVT_TARGET = EVT_W'(NUM_EVENTS);

  // Elaboration-time parameter sanity checks.
  generate
    if (ACC_W < DATA_W) begin : gErrAccW
      $error("capture_accumulator: ACC_W must be >= DATA_W");
    end
    if (RECORD_LEN < 2) begin : gErrRecLen
      $error("capture_accumulator: RECORD_LEN must be >= 2");
    end
    if (DEPTH < RECORD_LEN) begin : gErrAddrW
      $error("capture_accumulator: 2**ADDR_W must be >= RECORD_LEN");
    end
    if (NUM_EVENTS < 1) begin : gErrEvents
      $error("capture_accumulator: NUM_EVENTS must be >= 1");
    end
    if ((64'd1 << EVT_W) <= 64'(NUM_EVENTS)) begin : gErrEvtW
      $error("capture_accumulator: 2**EVT_W must exceed NUM_EVENTS");
    end
`ifdef CAPTURE_ACC_AVG_EN
    if ((NUM_EVENTS & (NUM_EVENTS - 1)) != 0) begin : gErrAvgPow2
      $error("capture_accumulator: averaging needs NUM_EVENTS to be a power of two");
    end
`endif
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    CAPTURE   = 3'd2,
    NEXT      = 3'd3,
    READOUT   = 3'd4
  } stateT;

  stateT state;

  logic [ACC_W-1:0] mem [DEPTH];
  logic [ACC_W-1:0] memQ;
  logic [ACC_W-1:0] memWord;

  logic              trigPrev;
  logic [ADDR_W-1:0] capIdx;

  // Capture read-modify-write stage: read issued last cycle, written this cycle.
  logic              stgValid;
  logic              stgFirst;
  logic              stgFwd;
  logic [ADDR_W-1:0] stgAddr;
  logic [DATA_W-1:0] stgSample;
  logic [ACC_W-1:0]  stgFwdData;

  // Readout: issued-read counter, in-flight read flag and one-word skid buffer.
  logic [CNT_W-1:0] rdCnt;
  logic             rdPend;
  logic             rdPendLast;
  logic             skidValid;
  logic             skidLast;
  logic [ACC_W-1:0] skidData;

  logic              trigAccept;
  logic              capIssue;
  logic              roIssue;
  logic              rdEn;
  logic [ADDR_W-1:0] rdAddr;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [ACC_W-1:0]  wrData;
  logic [ACC_W-1:0]  operand;
  logic [SUM_W-1:0]  sumWide;
  logic              satHit;
  logic              outFree;
  logic              outFire;
  logic              nextOutValid;
  logic              nextSkidValid;

  always_comb begin
    trigAccept = (state == WAIT_TRIG) && trig && !trigPrev && capture_en;
    capIssue   = trigAccept || (state == CAPTURE);

    outFree = !out_valid || out_ready;
    outFire = out_valid && out_ready;

    nextOutValid  = 1'b1;
    nextSkidValid = skidValid || rdPend;
    if (outFree) begin
      nextOutValid  = skidValid || rdPend;
      nextSkidValid = skidValid && rdPend;
    end

    // Only launch a read when a slot is guaranteed for its data next cycle.
    roIssue = (state == READOUT) && (rdCnt < REC_CNT) && !(nextOutValid && nextSkidValid);
    rdEn    = capIssue || roIssue;

    rdAddr = '0;
    if (state == CAPTURE) begin
      rdAddr = capIdx;
    end else if (state == READOUT) begin
      rdAddr = rdCnt[ADDR_W-1:0];
    end

    wrEn   = stgValid;
    wrAddr = stgAddr;

    operand = stgFwd ? stgFwdData : memQ;
    if (stgFirst) begin
      operand = '0;
    end
    sumWide = {1'b0, operand} + SUM_W'(stgSample);
    satHit  = sumWide[ACC_W];
    wrData  = satHit ? {ACC_W{1'b1}} : sumWide[ACC_W-1:0];
  end

`ifdef CAPTURE_ACC_AVG_EN
  localparam int unsigned AVG_SH = $clog2(NUM_EVENTS);
  assign memWord = memQ >> AVG_SH;
`else
  assign memWord = memQ;
`endif

  // Accumulator RAM: one synchronous read port, one write port, no reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    if (rdEn) begin
      memQ <= mem[rdAddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b1;
      event_count <= '0;
      sat_flag    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      trigPrev    <= 1'b0;
      capIdx      <= '0;
      stgValid    <= 1'b0;
      stgFirst    <= 1'b0;
      stgFwd      <= 1'b0;
      stgAddr     <= '0;
      stgSample   <= '0;
      stgFwdData  <= '0;
      rdCnt       <= '0;
      rdPend      <= 1'b0;
      rdPendLast  <= 1'b0;
      skidValid   <= 1'b0;
      skidLast    <= 1'b0;
      skidData    <= '0;
    end else begin
      trigPrev <= trig;

      stgValid <= capIssue;
      if (capIssue) begin
        stgAddr    <= rdAddr;
        stgSample  <= sample_in;
        stgFirst   <= (event_count == '0);
        stgFwd     <= wrEn && (wrAddr == rdAddr);
        stgFwdData <= wrData;
      end
      if (stgValid && satHit) begin
        sat_flag <= 1'b1;
      end

      rdPend <= roIssue;
      if (roIssue) begin
        rdCnt      <= rdCnt + CNT_W'(1);
        rdPendLast <= (rdCnt == REC_CNT - CNT_W'(1));
      end

      // Output register takes the skid word first so index order is preserved.
      if (outFree) begin
        out_valid <= nextOutValid;
        if (skidValid) begin
          out_data <= skidData;
          out_last <= skidLast;
        end else if (rdPend) begin
          out_data <= memWord;
          out_last <= rdPendLast;
        end else begin
          out_last <= 1'b0;
        end
      end
      if (outFree ? (skidValid && rdPend) : rdPend) begin
        skidData <= memWord;
        skidLast <= rdPendLast;
      end
      skidValid <= nextSkidValid;

      case (state)
        IDLE: begin
          state <= WAIT_TRIG;
          busy  <= 1'b0;
        end
        WAIT_TRIG: begin
          if (trigAccept) begin
            state  <= CAPTURE;
            busy   <= 1'b1;
            capIdx <= ADDR_W'(1);
          end
        end
        CAPTURE: begin
          if (capIdx == LAST_IDX) begin
            state <= NEXT;
          end else begin
            capIdx <= capIdx + ADDR_W'(1);
          end
        end
        NEXT: begin
          event_count <= event_count + EVT_W'(1);
          if (event_count + EVT_W'(1) == EVT_TARGET) begin
            state <= READOUT;
          end else begin
            state <= WAIT_TRIG;
            busy  <= 1'b0;
          end
        end
        READOUT: begin
          if (outFire && out_last) begin
            state       <= WAIT_TRIG;
            busy        <= 1'b0;
            event_count <= '0;
            sat_flag    <= 1'b0;
            rdCnt       <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_accumulator.sv
// Scoreboard bench for capture_accumulator: RECORD_LEN=8, NUM_EVENTS=4, ACC_W=9 so saturation is reachable.
module tb_capture_accumulator;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ACC_W      = 9;
  localparam int unsigned RECORD_LEN = 8;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned NUM_EVENTS = 4;
  localparam int unsigned EVT_W      = 8;
`ifdef CAPTURE_ACC_AVG_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  typedef struct packed {
    logic             last;
    logic [ACC_W-1:0] data;
  } expT;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] sample_in;
  logic              trig;
  logic              capture_en;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic [EVT_W-1:0]  event_count;
  logic              sat_flag;

  int  errors = 0;
  int  checks = 0;
  int  evt = 0;
  int  readyMode = 0;
  int  cycleCnt = 0;
  expT expQ[$];

  capture_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .RECORD_LEN(RECORD_LEN),
    .ADDR_W(ADDR_W), .NUM_EVENTS(NUM_EVENTS), .EVT_W(EVT_W)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .trig(trig),
    .capture_en(capture_en), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .busy(busy),
    .event_count(event_count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
  initial begin
    logic [3:0] pat;
    int phase;
    pat = 4'b1001;
    phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cycleCnt++;
      if (readyMode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = pat[phase];
        phase = (phase + 1) % 4;
      end
    end
  end

  // Monitor: every valid word must match the scoreboard head; pop on transfer.
  initial begin
    bit  stallPrev;
    bit  prevWasLast;
    int  lastXfer;
    expT e;
    stallPrev   = 1'b0;
    prevWasLast = 1'b1;
    lastXfer    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stallPrev   = 1'b0;
        prevWasLast = 1'b1;
      end else begin
        if (stallPrev) check("valid_held_while_stalled", 32'(out_valid), 32'd1);
        if (out_valid === 1'b1) begin
          if (expQ.size() == 0) begin
            check("spurious_valid", 32'(out_valid), 32'd0);
          end else begin
            e = expQ[0];
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_last", 32'(out_last), 32'(e.last));
            if (out_ready) begin
              void'(expQ.pop_front());
              if (readyMode == 0 && !prevWasLast) check("back_to_back", 32'(cycleCnt), 32'(lastXfer + 1));
              lastXfer    = cycleCnt;
              prevWasLast = e.last;
            end
          end
        end
        stallPrev = (out_valid === 1'b1) && !out_ready;
      end
    end
  end

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // One accepted trigger: sample index 0 rides on the trigger cycle.
  task automatic runEvent(input int base, input int step, input bit disturb);
    waitIdle("idle_before_trig");
    capture_en = 1'b1;
    trig = 1'b1;
    for (int i = 0; i < RECORD_LEN; i++) begin
      sample_in = DATA_W'(base + step * i);
      if (i > 0) trig = disturb && (i == 3);
      if (disturb && i == 5) capture_en = 1'b0;
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
    sample_in = '0;
    capture_en = 1'b1;
    @(posedge clk);
    #1;
    evt++;
    check("event_count_after_event", 32'(event_count), 32'(evt));
  endtask

  task automatic rejectTrig();
    waitIdle("idle_before_rejected_trig");
    capture_en = 1'b0;
    trig = 1'b1;
    @(posedge clk);
    #1;
    trig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    capture_en = 1'b1;
    check("rejected_trig_busy", 32'(busy), 32'd0);
    check("rejected_trig_count", 32'(event_count), 32'(evt));
  endtask

  task automatic pushWords(input int base, input int step);
    expT e;
    for (int i = 0; i < RECORD_LEN; i++) begin
      e.data = ACC_W'((base + step * i) >> SH);
      e.last = (i == RECORD_LEN - 1);
      expQ.push_back(e);
    end
  endtask

  task automatic finishReadout(input bit expSat, input bit trigDuring);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 3) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("first_valid_latency", 32'(out_valid), 32'd1);
    check("sat_flag_in_readout", 32'(sat_flag), 32'(expSat));
    if (trigDuring) begin
      trig = 1'b1;
      @(posedge clk);
      #1;
      trig = 1'b0;
    end
    waitIdle("idle_after_readout");
    check("event_count_cleared", 32'(event_count), 32'd0);
    check("sat_flag_cleared", 32'(sat_flag), 32'd0);
    check("out_valid_low_after", 32'(out_valid), 32'd0);
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("stays_idle", 32'(busy), 32'd0);
    evt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    trig = 1'b0;
    capture_en = 1'b1;
    sample_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_event_count", 32'(event_count), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    rst = 1'b0;

    // Ramp 0..7 four times, free-flowing output: 0,4,...,28.
    repeat (NUM_EVENTS) runEvent(0, 1, 1'b0);
    pushWords(0, 4);
    finishReadout(1'b0, 1'b0);

    // Same stimulus under back-pressure.
    readyMode = 1;
    repeat (NUM_EVENTS) runEvent(0, 1, 1'b0);
    pushWords(0, 4);
    finishReadout(1'b0, 1'b0);
    readyMode = 0;

    // Constant 0xFF: 0x3FC saturates to 0x1FF.
    repeat (NUM_EVENTS) runEvent(255, 0, 1'b0);
    pushWords(511, 0);
    finishReadout(1'b1, 1'b0);

    // Rejected and ignored triggers; samples 1..8 give 4,8,...,32.
    rejectTrig();
    runEvent(1, 1, 1'b1);
    rejectTrig();
    repeat (NUM_EVENTS - 1) runEvent(1, 1, 1'b1);
    pushWords(4, 4);
    finishReadout(1'b0, 1'b1);

    // Asynchronous reset in the middle of the third capture.
    repeat (2) runEvent(0, 1, 1'b0);
    waitIdle("idle_before_aborted_trig");
    trig = 1'b1;
    sample_in = 8'd5;
    @(posedge clk);
    #1;
    trig = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_event_count", 32'(event_count), 32'd0);
    check("midrst_sat_flag", 32'(sat_flag), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_in = '0;
    evt = 0;
    repeat (NUM_EVENTS) runEvent(10, 0, 1'b0);
    pushWords(40, 0);
    finishReadout(1'b0, 1'b0);

    // Constant 100 four times, then three of 100 and one of 0.
    repeat (NUM_EVENTS) runEvent(100, 0, 1'b0);
    pushWords(400, 0);
    finishReadout(1'b0, 1'b0);
    repeat (NUM_EVENTS - 1) runEvent(100, 0, 1'b0);
    runEvent(0, 0, 1'b0);
    pushWords(300, 0);
    finishReadout(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
